// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush qualifier generator and data-memory
// request gate. States WARM -> RUN <-> MEMDONE, plus a sticky HALT.
// Optional build macro: HAZARD_STATS_EN adds the stall_cnt/flush_cnt
// saturating statistics counters and their ports.
//
// state   | meaning
// --------+---------------------------------------------------------------
// WARM    | first cycle after reset, every output held low
// RUN     | normal issue; memory stall applied while a data access is pending
// MEMDONE | data returned before the latches advanced; request lines gated off
// HALT    | halt reached WB; pipeline frozen until reset
module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             idex_dREN,
   input  logic [REG_W-1:0] idex_wsel,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic             ex_redirect,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_stall,
   output logic             idex_flush,
   output logic             exmem_stall,
   output logic             dmem_ren,
   output logic             dmem_wen,
   output logic             halt
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      WARM    = 2'd0,
      RUN     = 2'd1,
      MEMDONE = 2'd2,
      HALT    = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_halt;
   logic   w_mem_req;
   logic   w_loaduse;

   // A counter narrower than one bit is meaningless; reject it at elaboration.
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("hazard_ctrl: CNT_W must be at least 1");
   end

   assign w_mem_req = exmem_dREN | exmem_dWEN;
   // A load into r0 never produces a usable value, so it never forces a bubble.
   assign w_loaduse = idex_dREN & (idex_wsel != '0) &
                      ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));

   // State register; reset lands in WARM so the dmem lines drop asynchronously.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= WARM;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_halt  <= (w_next == HALT);
      end
   end

   // Next state and qualifier outputs, highest-priority hazard first.
   always_comb begin
      w_next      = r_state;
      pc_en       = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
      dmem_ren    = 1'b0;
      dmem_wen    = 1'b0;
      case (r_state)
         WARM: begin
            w_next = RUN;
         end
         RUN, MEMDONE: begin
            if ((r_state == RUN) && w_mem_req && !dhit) begin
               ifid_stall  = 1'b1;
               idex_stall  = 1'b1;
               exmem_stall = 1'b1;
            end else if (ex_redirect) begin
               pc_en      = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (w_loaduse) begin
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
            end else begin
               pc_en = 1'b1;
            end
            if (r_state == RUN) begin
               // Requests stay up through the dhit cycle; MEMDONE then blocks a reissue.
               dmem_ren = exmem_dREN;
               dmem_wen = exmem_dWEN;
               if (w_mem_req && dhit && !ihit) begin
                  w_next = MEMDONE;
               end
            end else if (ihit) begin
               w_next = RUN;
            end
            if (memwb_halt) begin
               w_next = HALT;
            end
         end
         default: begin
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
         end
      endcase
   end

   assign halt = r_halt;

`ifdef HAZARD_STATS_EN
   logic w_active;
   assign w_active = (r_state == RUN) | (r_state == MEMDONE);

   // Saturating counts of lost issue cycles and of consumed redirects.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (w_active && !pc_en && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (w_active && ex_redirect && ihit && !(&flush_cnt)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks followed by randomized
// stimulus compared every cycle against a behavioural model.
module tb_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int CNT_W = 32;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             ihit, dhit, ifid_uses_rt, idex_dREN;
   logic             exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt;
   logic [REG_W-1:0] ifid_rs, ifid_rt, idex_wsel;
   logic             pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic             exmem_stall, dmem_ren, dmem_wen, halt;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
      .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
      .ex_redirect(ex_redirect), .memwb_halt(memwb_halt),
      .pc_en(pc_en), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_stall(idex_stall), .idex_flush(idex_flush),
      .exmem_stall(exmem_stall), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
      .halt(halt)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   // mode: 0 = warm-up cycle, 1 = running, 2 = data done / awaiting ihit, 3 = halted
   int          m_mode;
   logic        m_halt;
   longint      m_stall, m_flush;

   function automatic bit load_use();
      if (!idex_dREN || idex_wsel == 0) return 0;
      if (idex_wsel == ifid_rs) return 1;
      return ifid_uses_rt && (idex_wsel == ifid_rt);
   endfunction

   // Expected vector {pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
   // exmem_stall, dmem_ren, dmem_wen, halt}.
   function automatic logic [8:0] expect_out();
      bit pc, fs, ff, ds, df, es, rr, ww;
      bit pending;
      pc = 0; fs = 0; ff = 0; ds = 0; df = 0; es = 0; rr = 0; ww = 0;
      pending = exmem_dREN || exmem_dWEN;
      if (m_mode == 3) begin
         fs = 1; ds = 1; es = 1;
      end else if (m_mode == 1 || m_mode == 2) begin
         if (m_mode == 1 && pending && !dhit) begin
            fs = 1; ds = 1; es = 1;
         end else if (ex_redirect) begin
            pc = 1; ff = 1; df = 1;
         end else if (load_use()) begin
            fs = 1; df = 1;
         end else begin
            pc = 1;
         end
         if (m_mode == 1) begin
            rr = exmem_dREN; ww = exmem_dWEN;
         end
      end
      return {pc, fs, ff, ds, df, es, rr, ww, m_halt};
   endfunction

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_mode  <= 0;
         m_halt  <= 1'b0;
         m_stall <= 0;
         m_flush <= 0;
      end else begin
         if (m_mode == 1 || m_mode == 2) begin
            if (!expect_out()[8] && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
            if (ex_redirect && ihit && m_flush < 64'hFFFF_FFFF) m_flush <= m_flush + 1;
         end
         case (m_mode)
            0: m_mode <= 1;
            1, 2: begin
               if (memwb_halt) begin
                  m_mode <= 3;
                  m_halt <= 1'b1;
               end else if (m_mode == 1 && (exmem_dREN || exmem_dWEN) && dhit && !ihit)
                  m_mode <= 2;
               else if (m_mode == 2 && ihit)
                  m_mode <= 1;
            end
            default: m_mode <= 3;
         endcase
      end
   end

   // Every-cycle comparison away from the active edge.
   always @(negedge CLK) begin
      logic [8:0] act, exp_v;
      act   = {pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, dmem_ren, dmem_wen, halt};
      exp_v = expect_out();
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL model_outputs t=%0t mode=%0d got=%b expected=%b", $time, m_mode, act, exp_v);
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
         errors++;
         $display("FAIL model_counters t=%0t got=%0d/%0d expected=%0d/%0d",
                  $time, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp_v);
      end
   endtask

   task automatic clear_in();
      ihit = 0; dhit = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
      idex_dREN = 0; idex_wsel = 0; exmem_dREN = 0; exmem_dWEN = 0;
      ex_redirect = 0; memwb_halt = 0;
   endtask

   // Advance one edge; inputs may be changed on return, then settle for checks.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int halt_cycles;
      nRST = 1'b0;
      clear_in();
      repeat (2) step();
      nRST = 1'b1;
      #2;
      chk("warm_pc_en", pc_en, 0);
      chk("warm_halt", halt, 0);
      chk("warm_ifid_stall", ifid_stall, 0);
      step(); #2;
      chk("run_pc_en", pc_en, 1);

      // load-use bubble, then the same with r0 as destination
      idex_dREN = 1; idex_wsel = 8; ifid_rs = 8; #2;
      chk("lu_pc_en", pc_en, 0);
      chk("lu_ifid_stall", ifid_stall, 1);
      chk("lu_idex_flush", idex_flush, 1);
      chk("lu_idex_stall", idex_stall, 0);
      idex_wsel = 0; #2;
      chk("lu_r0_pc_en", pc_en, 1);
      chk("lu_r0_ifid_stall", ifid_stall, 0);
      step();

      // memory stall for three cycles, then data-done before ihit
      clear_in();
      exmem_dREN = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("mem_exmem_stall", exmem_stall, 1);
         chk("mem_dmem_ren", dmem_ren, 1);
         chk("mem_pc_en", pc_en, 0);
         step();
      end
      dhit = 1; #2;
      chk("mem_dhit_ren", dmem_ren, 1);
      chk("mem_dhit_stall", exmem_stall, 0);
      step(); #2;
      chk("memdone_ren", dmem_ren, 0);
      chk("memdone_pc_en", pc_en, 1);
      dhit = 0; ihit = 1; #2;
      chk("memdone_no_stall", exmem_stall, 0);
      step();
      ihit = 0; #2;
      chk("back_in_run_stall", exmem_stall, 1);
      step();

      // redirect coincident with load-use
      clear_in();
      idex_dREN = 1; idex_wsel = 3; ifid_rt = 3; ifid_uses_rt = 1;
      ex_redirect = 1; ihit = 1; #2;
      chk("rd_ifid_flush", ifid_flush, 1);
      chk("rd_idex_flush", idex_flush, 1);
      chk("rd_pc_en", pc_en, 1);
      chk("rd_ifid_stall", ifid_stall, 0);
`ifdef HAZARD_STATS_EN
      chk("rd_flush_cnt_before", flush_cnt, 0);
`endif
      step();
`ifdef HAZARD_STATS_EN
      #2;
      chk("rd_flush_cnt_after", flush_cnt, 1);
`endif

      // memory stall beats redirect
      clear_in();
      exmem_dWEN = 1; ex_redirect = 1; #2;
      chk("ms_rd_ifid_flush", ifid_flush, 0);
      chk("ms_rd_idex_flush", idex_flush, 0);
      chk("ms_rd_dmem_wen", dmem_wen, 1);
      chk("ms_rd_pc_en", pc_en, 0);
      step();

      // halt is sticky until reset
      clear_in();
      memwb_halt = 1;
      step();
      memwb_halt = 0; ihit = 1; #2;
      chk("halt_set", halt, 1);
      chk("halt_pc_en", pc_en, 0);
      chk("halt_idex_stall", idex_stall, 1);
      chk("halt_exmem_stall", exmem_stall, 1);
      repeat (3) step();
      #2;
      chk("halt_sticky", halt, 1);
      nRST = 0; #1;
      chk("halt_cleared_by_reset", halt, 0);
      step();
      nRST = 1;

      // randomized phase
      halt_cycles = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         step();
         if (m_mode == 3) halt_cycles++;
         if (halt_cycles > 4 || $urandom_range(0, 499) == 0) begin
            nRST = 0;
            halt_cycles = 0;
         end else begin
            nRST = 1;
         end
         ihit         = $urandom_range(0, 3) != 0;
         dhit         = $urandom_range(0, 2) == 0;
         ifid_rs      = REG_W'($urandom_range(0, 3));
         ifid_rt      = REG_W'($urandom_range(0, 3));
         ifid_uses_rt = $urandom_range(0, 1) == 1;
         idex_dREN    = $urandom_range(0, 2) == 0;
         idex_wsel    = REG_W'($urandom_range(0, 3));
         exmem_dREN   = $urandom_range(0, 3) == 0;
         exmem_dWEN   = !exmem_dREN && $urandom_range(0, 4) == 0;
         ex_redirect  = $urandom_range(0, 5) == 0;
         memwb_halt   = $urandom_range(0, 149) == 0;
      end
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
